// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the shared-FIFO write arbiter.
package fifo_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after last_grant_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (int'(last_grant_i) + i) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates N_REQ writers onto one shared FIFO write port and tracks occupancy.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   rd_req,
  output logic [N_REQ-1:0]       grant,
  output logic                   fifo_en_write,
  output logic [WIDTH-1:0]       fifo_data_in,
  output logic                   fifo_en_read,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic                   underflow_err
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_state_e      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q;
  logic [WIDTH-1:0] data_q;
  logic             wen_q, ren_q, uflow_q;

  logic [N_REQ-1:0] win_gnt;
  logic             win_valid;
  logic [WIDTH-1:0] win_data;
  logic [IDX_W-1:0] win_idx;
  logic             rd_acc, wr_acc;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i        (req),
    .last_grant_i (last_q),
    .gnt_o        (win_gnt),
    .valid_o      (win_valid)
  );

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc   = rd_req && (state_q != ST_EMPTY);
    wr_acc   = win_valid && ((state_q != ST_FULL) || rd_acc);
    win_data = '0;
    win_idx  = last_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_gnt[k]) begin
        win_data = win_data | wdata[k*WIDTH +: WIDTH];
        win_idx  = IDX_W'(k);
      end
    end
    last_d  = wr_acc ? win_idx : last_q;
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    state_d = ST_ACTIVE;
    if (count_d == '0)          state_d = ST_EMPTY;
    else if (count_d == DEPTH_C) state_d = ST_FULL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      grant_q <= wr_acc ? win_gnt : '0;
      data_q  <= wr_acc ? win_data : '0;
      wen_q   <= wr_acc;
      ren_q   <= rd_acc;
      uflow_q <= uflow_q | (rd_req && (count_q == '0));
    end
  end

  assign grant         = grant_q;
  assign fifo_en_write = wen_q;
  assign fifo_data_in  = data_q;
  assign fifo_en_read  = ren_q;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign underflow_err = uflow_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: behavioural model feeds a scoreboard queue, plus directed vector table.
module tb_fifo_write_arbiter;
  localparam int N = 4, D = 16, W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wdata = '0;
  logic         rd_req = 1'b0;
  logic [N-1:0] grant;
  logic         fifo_en_write, fifo_en_read, full, empty, underflow_err;
  logic [W-1:0] fifo_data_in;
  logic [4:0]   count;

  fifo_write_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata), .rd_req(rd_req),
    .grant(grant), .fifo_en_write(fifo_en_write), .fifo_data_in(fifo_data_in),
    .fifo_en_read(fifo_en_read), .count(count), .full(full), .empty(empty),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic         wen;
    logic [W-1:0] data;
    logic         ren;
    int           cnt;
    logic         uflow;
  } exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic           rd;
    logic [N*W-1:0] wd;
    logic [N-1:0]   e_grant;
    logic [W-1:0]   e_data;
    logic           e_ren;
    int             e_cnt;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0, n_err = 0;
  int   m_count = 0, m_last = N - 1;
  logic m_uflow = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: model predicts, pushes expectation, DUT result popped after the edge.
  task automatic step(input logic [N-1:0] r, input logic rd, input logic [N*W-1:0] wd);
    exp_t e;
    int   win;
    bit   rd_ok, wr_ok;
    @(negedge clk);
    req = r; rd_req = rd; wdata = wd;
    win = -1;
    for (int i = 1; i <= N && win < 0; i++)
      if (r[(m_last + i) % N]) win = (m_last + i) % N;
    rd_ok = rd && (m_count > 0);
    wr_ok = (win >= 0) && ((m_count < D) || rd_ok);
    if (rd && m_count == 0) m_uflow = 1'b1;
    e.grant = '0; e.data = '0;
    if (wr_ok) begin
      e.grant[win] = 1'b1;
      e.data = wd[win*W +: W];
      m_last = win;
    end
    e.wen = wr_ok;
    e.ren = rd_ok;
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    e.cnt = m_count;
    e.uflow = m_uflow;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("grant", 32'(grant), 32'(e.grant));
      chk("fifo_en_write", 32'(fifo_en_write), 32'(e.wen));
      chk("fifo_data_in", 32'(fifo_data_in), 32'(e.data));
      chk("fifo_en_read", 32'(fifo_en_read), 32'(e.ren));
      chk("count", 32'(count), 32'(e.cnt));
      chk("full", 32'(full), 32'(e.cnt == D));
      chk("empty", 32'(empty), 32'(e.cnt == 0));
      chk("underflow_err", 32'(underflow_err), 32'(e.uflow));
    end
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{4'b1111, 1'b0, 32'h44332211, 4'b0001, 8'h11, 1'b0, 1};
    vt[1] = '{4'b1111, 1'b0, 32'h44332211, 4'b0010, 8'h22, 1'b0, 2};
    vt[2] = '{4'b1111, 1'b0, 32'h44332211, 4'b0100, 8'h33, 1'b0, 3};
    vt[3] = '{4'b1111, 1'b0, 32'h44332211, 4'b1000, 8'h44, 1'b0, 4};
    vt[4] = '{4'b0100, 1'b0, 32'h00A50000, 4'b0100, 8'hA5, 1'b0, 5};
    vt[5] = '{4'b0000, 1'b1, 32'h00000000, 4'b0000, 8'h00, 1'b1, 4};
    vt[6] = '{4'b0011, 1'b0, 32'h0000BBAA, 4'b0001, 8'hAA, 1'b0, 5};
    vt[7] = '{4'b0011, 1'b1, 32'h0000BBAA, 4'b0010, 8'hBB, 1'b1, 5};

    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_uflow", 32'(underflow_err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      step(vt[v].req, vt[v].rd, vt[v].wd);
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].e_grant));
      chk($sformatf("vec%0d_data", v), 32'(fifo_data_in), 32'(vt[v].e_data));
      chk($sformatf("vec%0d_ren", v), 32'(fifo_en_read), 32'(vt[v].e_ren));
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(vt[v].e_cnt));
    end

    // Fill to DEPTH, then a write alone must stall, a write with a read must pass.
    for (int i = 0; i < 11; i++) step(4'b0001, 1'b0, 32'($urandom));
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    step(4'b0001, 1'b0, 32'h000000C3);
    chk("full_stall_grant", 32'(grant), 0);
    chk("full_stall_full", 32'(full), 1);
    step(4'b0001, 1'b1, 32'h000000C3);
    chk("full_rw_grant", 32'(grant), 32'b0001);
    chk("full_rw_ren", 32'(fifo_en_read), 1);
    chk("full_rw_count", 32'(count), 16);

    for (int i = 0; i < 16; i++) step(4'b0000, 1'b1, '0);
    chk("drain_empty", 32'(empty), 1);
    step(4'b0000, 1'b1, '0);
    chk("uflow_ren", 32'(fifo_en_read), 0);
    chk("uflow_set", 32'(underflow_err), 1);
    for (int i = 0; i < 7; i++) step(4'($urandom_range(1, 15)), 1'b0, 32'($urandom));
    chk("uflow_sticky", 32'(underflow_err), 1);
    chk("pre_rst_count", 32'(count), 7);
    chk("pre_rst_wen", 32'(fifo_en_write), 1);

    // Asynchronous reset mid-burst, between clock edges.
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_wen", 32'(fifo_en_write), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_uflow", 32'(underflow_err), 0);
    m_count = 0; m_last = N - 1; m_uflow = 1'b0;
    req = '0; rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1111, 1'b0, 32'h44332211);
    chk("post_rst_grant", 32'(grant), 32'b0001);
    step(4'b1010, 1'b0, 32'h44332211);
    chk("post_rst_rr", 32'(grant), 32'b0010);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
